divider_seq_16bit: RTL and testbench



---
 rtl/divider_seq_16bit.sv | 173 +++++++++++++++++
 tb/tb_divider_seq_16bit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_16bit.sv
// divider_seq_16bit: multi-cycle 16-bit signed divider (restoring shift-subtract).
// Quotient truncates toward zero, remainder takes the dividend's sign.
// Overflow (0x8000 / -1) saturates to 0x7FFF; divide-by-zero saturates by dividend sign.
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   start        - request, accepted only when idle
//   a, b         - dividend / divisor (two's complement), sampled at acceptance
//   busy         - operation in flight
//   done         - one-cycle pulse, q/r/ovfl/div0 valid
//   q, r         - quotient / remainder, held until the next completion
//   ovfl, div0   - quotient saturated / divisor was zero
module divider_seq_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic [15:0] r,
    output logic        ovfl,
    output logic        div0
);

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG  = 16'h8000;
    localparam logic [W-1:0]  MOST_POS  = 16'h7FFF;
    localparam logic [W-1:0]  MINUS_ONE = 16'hFFFF;

    logic [1:0]    state, state_next;
    logic [W-1:0]  a_reg, a_reg_next;
    logic [W-1:0]  b_reg, b_reg_next;
    logic [W-1:0]  bmag, bmag_next;
    logic [W-1:0]  dvd, dvd_next;
    logic [W:0]    rem, rem_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          sign_q, sign_q_next;
    logic          sign_r, sign_r_next;
    logic          busy_next, done_next, ovfl_next, div0_next;
    logic [W-1:0]  q_next, r_next;

    // One restoring step: shift the next dividend bit in, trial-subtract |b|.
    // rem < |b| <= 0x8000 keeps rem_sh below 2^16, so diff[W] is a clean borrow.
    logic [W:0] rem_sh;
    logic [W:0] diff;
    assign rem_sh = {rem[W-1:0], dvd[W-1]};
    assign diff   = rem_sh - {1'b0, bmag};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            bmag   <= '0;
            dvd    <= '0;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            q      <= '0;
            r      <= '0;
            ovfl   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            state  <= state_next;
            a_reg  <= a_reg_next;
            b_reg  <= b_reg_next;
            bmag   <= bmag_next;
            dvd    <= dvd_next;
            rem    <= rem_next;
            cnt    <= cnt_next;
            sign_q <= sign_q_next;
            sign_r <= sign_r_next;
            busy   <= busy_next;
            done   <= done_next;
            q      <= q_next;
            r      <= r_next;
            ovfl   <= ovfl_next;
            div0   <= div0_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next  = state;
        a_reg_next  = a_reg;
        b_reg_next  = b_reg;
        bmag_next   = bmag;
        dvd_next    = dvd;
        rem_next    = rem;
        cnt_next    = cnt;
        sign_q_next = sign_q;
        sign_r_next = sign_r;
        busy_next   = busy;
        done_next   = 1'b0;
        q_next      = q;
        r_next      = r;
        ovfl_next   = ovfl;
        div0_next   = div0;

        case (state)
            IDLE: begin
                if (start) begin
                    a_reg_next  = a;
                    b_reg_next  = b;
                    sign_q_next = a[W-1] ^ b[W-1];
                    sign_r_next = a[W-1];
                    // Two's-complement negate of 0x8000 is 0x8000, exact as unsigned.
                    dvd_next    = a[W-1] ? W'(~a + 16'd1) : a;
                    bmag_next   = b[W-1] ? W'(~b + 16'd1) : b;
                    rem_next    = '0;
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    state_next  = (b == '0) ? FIX : CALC;
                end
            end

            CALC: begin
                if (!diff[W]) begin
                    rem_next = diff;
                    dvd_next = {dvd[W-2:0], 1'b1};
                end else begin
                    rem_next = rem_sh;
                    dvd_next = {dvd[W-2:0], 1'b0};
                end
                cnt_next = cnt + 5'd1;
                if (cnt == LAST_ITER) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
                if (b_reg == '0) begin
                    q_next    = a_reg[W-1] ? MOST_NEG : MOST_POS;
                    r_next    = a_reg;
                    ovfl_next = 1'b0;
                    div0_next = 1'b1;
                end else if (a_reg == MOST_NEG && b_reg == MINUS_ONE) begin
                    q_next    = MOST_POS;
                    r_next    = '0;
                    ovfl_next = 1'b1;
                    div0_next = 1'b0;
                end else begin
                    // dvd now holds the quotient magnitude, rem the remainder magnitude
                    q_next    = sign_q ? W'(~dvd + 16'd1) : dvd;
                    r_next    = sign_r ? W'(~rem[W-1:0] + 16'd1) : rem[W-1:0];
                    ovfl_next = 1'b0;
                    div0_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_divider_seq_16bit.sv
// tb_divider_seq_16bit: directed vectors for divider_seq_16bit with a scoreboard.
// The driver pushes the expected result and completion edge; a negedge monitor
// pops and compares whenever done is seen.
module tb_divider_seq_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovfl;
    logic        div0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        ovfl;
        logic        div0;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    divider_seq_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .ovfl  (ovfl),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after edge e it reads e
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (busy) check("done_busy_overlap", 32'(busy), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_edge", 32'(cyc), 32'(e.due));
                    check("q", 32'(q), 32'(e.q));
                    check("r", 32'(r), 32'(e.r));
                    check("ovfl", 32'(ovfl), 32'(e.ovfl));
                    check("div0", 32'(div0), 32'(e.div0));
                end
            end
        end
    end

    task automatic push(input logic [15:0] eq, input logic [15:0] er,
                        input logic eo, input logic ed, input int due);
        exp_t e;
        e.q = eq; e.r = er; e.ovfl = eo; e.div0 = ed; e.due = due;
        sb.push_back(e);
    endtask

    // Single-cycle start pulse; returns with cyc == acceptance edge
    task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic eo, input logic ed, input int lat);
        @(posedge clk); #1;
        a = va; b = vb; start = 1'b1;
        push(eq, er, eo, ed, cyc + 1 + lat);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_flags", 32'({ovfl, div0}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Signed division and boundaries
        issue(16'd100,  16'd7,      16'h000E, 16'h0002, 1'b0, 1'b0, 17);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_idle();
        issue(16'hFF9C, 16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17); wait_idle();
        issue(16'd100,  16'hFFF9,   16'hFFF2, 16'h0002, 1'b0, 1'b0, 17); wait_idle();
        issue(16'h8000, 16'h0001,   16'h8000, 16'h0000, 1'b0, 1'b0, 17); wait_idle();
        issue(16'h7FFF, 16'h8000,   16'h0000, 16'h7FFF, 1'b0, 1'b0, 17); wait_idle();
        issue(16'hFFF9, 16'd100,    16'h0000, 16'hFFF9, 1'b0, 1'b0, 17); wait_idle();
        issue(16'h8000, 16'hFFFF,   16'h7FFF, 16'h0000, 1'b1, 1'b0, 17); wait_idle();
        issue(16'hFFF0, 16'h0000,   16'h8000, 16'hFFF0, 1'b0, 1'b1, 1);  wait_idle();
        issue(16'h0000, 16'h0000,   16'h7FFF, 16'h0000, 1'b0, 1'b1, 1);  wait_idle();
        issue(16'd9,    16'd4,      16'h0002, 16'h0001, 1'b0, 1'b0, 17); wait_idle();

        // Held start: back-to-back acceptance, mid-operation input change ignored
        @(posedge clk); #1;
        a = 16'd50; b = 16'd5; start = 1'b1;
        k = cyc + 1;
        push(16'd10, 16'd0, 1'b0, 1'b0, k + 17);
        push(16'd10, 16'd0, 1'b0, 1'b0, k + 35);
        repeat (6) @(posedge clk); #1;   // after edge k+5
        a = 16'h1234;
        repeat (5) @(posedge clk); #1;   // after edge k+10
        a = 16'd50;
        repeat (8) @(posedge clk); #1;   // after edge k+18, second op accepted
        check("busy_rearm", 32'(busy), 32'd1);
        start = 1'b0; a = 16'h1111; b = 16'h0003;
        wait_idle();

        // Start pulse during busy is ignored
        issue(16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 1'b0, 17);
        @(posedge clk); #1;              // after edge k+1
        a = 16'd1; b = 16'd1; start = 1'b1;
        @(posedge clk); @(posedge clk); #1;  // edge k+3 passed with start high
        start = 1'b0;
        wait_idle();
        repeat (20) @(posedge clk);

        // Reset mid-operation aborts with no done
        @(posedge clk); #1;
        a = 16'd100; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);       // edge k+5
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_r", 32'(r), 32'd0);
        check("midrst_flags", 32'({ovfl, div0}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        issue(16'd9, 16'd4, 16'h0002, 16'h0001, 1'b0, 1'b0, 17); wait_idle();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
